alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal values 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 ALUControl  input  3  op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 MUL (unsigned, multi-cycle), 111 PASSB.
REQ-009 out_valid  output  1  Result/ALUFlags valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 Result  output  WIDTH  registered result.
REQ-012 ALUFlags  output  4  registered flags: [0] N, [1] Z, [2] C, [3] V.

Function
REQ-013 Request accepted on a rising edge where in_valid & in_ready; A, B, ALUControl captured at that edge.
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 in_ready = (state==IDLE) | (state==DONE & out_ready); in_ready = 0 in BUSY.
REQ-016 out_valid = 1 exactly in DONE.
REQ-017 Single-cycle ops (all except MUL): accept -> DONE next edge; out_valid asserted 1 cycle after accept.
REQ-018 MUL: accept -> BUSY; shift-add, one multiplier bit per cycle; BUSY lasts exactly WIDTH cycles; then DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-019 DONE held, Result/ALUFlags stable, while out_ready = 0.
REQ-020 DONE & out_ready & in_valid: result retires and new request accepted same edge (back-to-back, 1 op/cycle for single-cycle ops); DONE & out_ready & !in_valid -> IDLE.
REQ-021 ADD/SUB: sum = A + (SUB ? ~B : B) + SUB, WIDTH+1 bits; C = carry-out bit WIDTH (SUB: C=1 means no borrow).
REQ-022 ADD/SUB V = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]), B' = operand after inversion.
REQ-023 SLT: Result = 1 if A < B signed else 0, computed from SUB N^V; C, V = 0.
REQ-024 AND, OR, XOR, PASSB: bitwise; C = 0, V = 0.
REQ-025 MUL: Result = low WIDTH bits of A*B; C = 0; V = 1 iff high WIDTH bits of the 2*WIDTH product nonzero.
REQ-026 All ops: N = Result[WIDTH-1]; Z = (Result == 0).
REQ-027 Flags and Result update together, only on the edge entering DONE.
REQ-028 Inputs ignored (no capture, no state change) while in_ready = 0.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, out_valid 0, Result 0, ALUFlags 0, multiply accumulator/counter 0.
REQ-030 Reset mid-MUL or in DONE discards the operation; no out_valid pulse after release.
REQ-031 in_ready = 1 on first edge after rst_n deasserts.

Verification (WIDTH=4)
REQ-032 ADD A=0111 B=0001 -> 1 cycle later out_valid, Result=1000, ALUFlags N=1 Z=0 C=0 V=1.
REQ-033 SUB A=0101 B=0101 -> Result=0000, N=0 Z=1 C=1 V=0; SLT A=1110 B=0001 -> Result=0001.
REQ-034 MUL A=0101 B=0011 -> in_ready=0 for 4 cycles, out_valid on cycle 5, Result=1111, V=0; MUL A=1111 B=1111 -> Result=0001, V=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles after ADD -> Result/ALUFlags stable, in_ready=0; then out_ready=1 with next AND request -> accepted same edge, AND result next cycle.
REQ-036 Back-to-back: 4 single-cycle ops with in_valid=out_ready=1 -> 4 consecutive out_valid cycles, results in order.
REQ-037 Assert rst_n=0 on cycle 2 of MUL -> all outputs 0 immediately, no out_valid after release, in_ready=1 next edge.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered Result/ALUFlags. Single-cycle ops finish on the
// edge after acceptance; MUL is a WIDTH-cycle shift-add sequence.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        count_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [3:0]           flags_reg;

  logic                 accept;
  logic                 is_mul;
  logic                 mul_last;

  // Shared adder: SLT reuses the subtract path and takes N^V as "less than".
  logic                 sub;
  logic [WIDTH-1:0]     b_op;
  logic [WIDTH:0]       sum;
  logic                 add_v;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  assign sub   = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
  assign b_op  = sub ? ~B : B;
  assign sum   = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
  assign add_v = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      OP_AND:   alu_res = A & B;
      OP_OR:    alu_res = A | B;
      OP_XOR:   alu_res = A ^ B;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_v};
      OP_PASSB: alu_res = B;
      default:  alu_res = '0;
    endcase
  end

  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign mul_last = (count_reg == LAST);

  assign is_mul    = (ALUControl == OP_MUL);
  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign Result    = result_reg;
  assign ALUFlags  = flags_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = is_mul ? BUSY : DONE;
      BUSY: if (mul_last) state_next = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_next = is_mul ? BUSY : DONE;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (is_mul) begin
          mcand_reg  <= {{WIDTH{1'b0}}, A};
          mplier_reg <= B;
          acc_reg    <= '0;
          count_reg  <= '0;
        end else begin
          result_reg <= alu_res;
          flags_reg  <= {alu_v, alu_c, (alu_res == '0), alu_res[WIDTH-1]};
        end
      end else if (state_reg == BUSY) begin
        acc_reg    <= acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
        if (mul_last) begin
          result_reg <= acc_next[WIDTH-1:0];
          flags_reg  <= {(acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0,
                         (acc_next[WIDTH-1:0] == '0), acc_next[WIDTH-1]};
        end
      end
    end
  end

endmodule
